// File: rtl/top_register_pkg.sv
// rtl/top_register_pkg.sv - shared defaults and data word type for the top_register delay line
package top_register_pkg;
  localparam int TOP_REGISTER_DEFAULT_WIDTH  = 4;
  localparam int TOP_REGISTER_DEFAULT_STAGES = 1;

  typedef logic [TOP_REGISTER_DEFAULT_WIDTH-1:0] top_register_word_t;
endpackage

// File: rtl/top_register_stage.sv
// rtl/top_register_stage.sv - single WIDTH-bit flop with synchronous active-high reset and load enable
module top_register_stage
  import top_register_pkg::*;
#(
  parameter int              WIDTH   = TOP_REGISTER_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset wins over the enable so a held pipeline can still be flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/top_register.sv
// rtl/top_register.sv - STAGES-deep WIDTH-bit delay line with synchronous active-high reset
// Defining TOP_REGISTER_CE_EN adds a ce input that freezes every stage while low.
module top_register
  import top_register_pkg::*;
#(
  parameter int               WIDTH   = TOP_REGISTER_DEFAULT_WIDTH,
  parameter int               STAGES  = TOP_REGISTER_DEFAULT_STAGES,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  input  logic             rst
`ifdef TOP_REGISTER_CE_EN
  ,
  input  logic             ce
`endif
);

  logic             en;
  logic [WIDTH-1:0] chain [STAGES+1];

`ifdef TOP_REGISTER_CE_EN
  assign en = ce;
`else
  assign en = 1'b1;
`endif

  assign chain[0] = d;

  // chain[k+1] is the output of stage k; q comes straight off the last flop.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    top_register_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (chain[g]),
      .q   (chain[g+1])
    );
  end

  assign q = chain[STAGES];

endmodule

// File: tb/tb_top_register.sv
// tb/tb_top_register.sv - directed and long-run checks of top_register in several configurations
// Exercises the ce input only when TOP_REGISTER_CE_EN is defined.
module tb_top_register;
  import top_register_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  top_register_word_t d0, q0;
  logic               rst0;
  logic [3:0]         d3, q3;
  logic               rst3;
  logic               d1, q1;
  logic [31:0]        d32, q32;
  logic               rst_r;
`ifdef TOP_REGISTER_CE_EN
  logic               ce0;
`endif

  logic        h1  [2];
  logic [31:0] h32 [4];

  top_register u_dut0 (
    .clk (clk), .d (d0), .q (q0), .rst (rst0)
`ifdef TOP_REGISTER_CE_EN
    , .ce (ce0)
`endif
  );

  top_register #(.WIDTH(4), .STAGES(3)) u_dut3 (
    .clk (clk), .d (d3), .q (q3), .rst (rst3)
`ifdef TOP_REGISTER_CE_EN
    , .ce (1'b1)
`endif
  );

  top_register #(.WIDTH(1), .STAGES(2), .RST_VAL(1'b1)) u_dut1 (
    .clk (clk), .d (d1), .q (q1), .rst (rst_r)
`ifdef TOP_REGISTER_CE_EN
    , .ce (1'b1)
`endif
  );

  top_register #(.WIDTH(32), .STAGES(4), .RST_VAL(32'hdead_beef)) u_dut32 (
    .clk (clk), .d (d32), .q (q32), .rst (rst_r)
`ifdef TOP_REGISTER_CE_EN
    , .ce (1'b1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    d0    = 4'b1001;
    rst0  = 1'b0;
    d3    = '0;
    rst3  = 1'b1;
    d1    = 1'b0;
    d32   = '0;
    rst_r = 1'b1;
`ifdef TOP_REGISTER_CE_EN
    ce0   = 1'b1;
`endif

    // Absolute-time checks around the 5/15/25 ns edges.
    #10 check("first_capture", {28'd0, q0}, 32'h9);
    #10 d0 = 4'b1101;
    #2  check("mid_cycle_hold", {28'd0, q0}, 32'h9);
    #8  check("second_capture", {28'd0, q0}, 32'hd);

    d0 = 4'b1111; rst0 = 1'b1;
    tick(); check("reset_value", {28'd0, q0}, 32'h0);
    tick(); check("reset_held", {28'd0, q0}, 32'h0);
    rst0 = 1'b0;
    tick(); check("after_reset", {28'd0, q0}, 32'hf);

`ifdef TOP_REGISTER_CE_EN
    d0 = 4'b0101; ce0 = 1'b1;
    tick(); check("ce_load", {28'd0, q0}, 32'h5);
    d0 = 4'b1010; ce0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); check("ce_hold", {28'd0, q0}, 32'h5);
    end
    ce0 = 1'b1;
    tick(); check("ce_resume", {28'd0, q0}, 32'ha);
    ce0 = 1'b0; rst0 = 1'b1;
    tick(); check("ce_rst_override", {28'd0, q0}, 32'h0);
    rst0 = 1'b0; ce0 = 1'b1;
`endif

    // Three-stage delay: the stream 1..4 reaches q two edges after each capture edge.
    tick(); check("s3_reset", {28'd0, q3}, 32'h0);
    rst3 = 1'b0;
    begin
      logic [3:0] stream [6];
      logic [3:0] expq   [6];
      stream = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0};
      expq   = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      for (int i = 0; i < 6; i++) begin
        d3 = stream[i];
        tick(); check($sformatf("s3_stream%0d", i), {28'd0, q3}, {28'd0, expq[i]});
      end
    end

    // Flush mid-stream: 5 and 6 are in flight when reset hits and must never show.
    d3 = 4'd5; tick();
    d3 = 4'd6; tick();
    rst3 = 1'b1; d3 = 4'd7;
    tick(); check("s3_flush0", {28'd0, q3}, 32'h0);
    rst3 = 1'b0; d3 = 4'd9;
    tick(); check("s3_flush1", {28'd0, q3}, 32'h0);
    tick(); check("s3_flush2", {28'd0, q3}, 32'h0);
    tick(); check("s3_refill", {28'd0, q3}, 32'h9);

    // Long random run on the 1-bit and 32-bit instances against a shift model.
    rst_r = 1'b1;
    tick(); tick();
    h1  = '{1'b1, 1'b1};
    h32 = '{32'hdead_beef, 32'hdead_beef, 32'hdead_beef, 32'hdead_beef};
    check("w1_reset", {31'd0, q1}, {31'd0, h1[1]});
    check("w32_reset", q32, h32[3]);
    rst_r = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      d1  = 1'($urandom_range(0, 1));
      d32 = $urandom;
      tick();
      h1[1]  = h1[0];
      h1[0]  = d1;
      h32[3] = h32[2];
      h32[2] = h32[1];
      h32[1] = h32[0];
      h32[0] = d32;
      check("w1_rand", {31'd0, q1}, {31'd0, h1[1]});
      check("w32_rand", q32, h32[3]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
